// File: rtl/spk_pkg.sv
// Shared flit-type encodings and helpers for the multi-channel spike-input stage.
package spk_pkg;
    localparam logic [2:0] SPIKE    = 3'b000;
    localparam logic [2:0] DATA     = 3'b001;
    localparam logic [2:0] DATA_END = 3'b010;
    localparam logic [2:0] WRITE    = 3'b110;
    localparam logic [2:0] READ     = 3'b111;

    function automatic int spk_clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic is_axon(input logic [2:0] t);
        return (t == SPIKE) || (t == DATA) || (t == DATA_END);
    endfunction

    function automatic logic is_cfg(input logic [2:0] t);
        return (t == WRITE) || (t == READ);
    endfunction
endpackage

// File: rtl/data_fifo.sv
// Show-ahead FIFO: the head word is readable combinationally whenever not empty.
module data_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  do_wr, do_rd;

    // A pop frees the slot, so a write into a full FIFO is accepted alongside it.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDR_WIDTH+1)'(2**ADDR_WIDTH));
    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
        end
    end
endmodule

// File: rtl/spk_in_rr_arb.sv
// Round-robin arbiter with a DATA-packet lock that pins grants to one channel.
module spk_in_rr_arb #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] is_data,
    input  logic [NCH-1:0] is_end,
    output logic           grant_vld,
    output logic [NCH-1:0] grant_oh,
    output logic [CHW-1:0] grant_idx
);
    logic [CHW-1:0] ptr_q, lock_ch_q;
    logic           lock_q;
    logic [NCH-1:0] req_eff;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
        assign req_eff[gi] = req[gi] && (!lock_q || lock_ch_q == CHW'(gi));
    end

    always_comb begin
        int c;
        c         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 0; k < NCH; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NCH) c = c - NCH;
            if (!grant_vld && req_eff[c]) begin
                grant_vld   = 1'b1;
                grant_idx   = CHW'(c);
                grant_oh[c] = 1'b1;
            end
        end
    end

    // The pointer stays frozen for the whole locked packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else if (grant_vld) begin
            if (!lock_q)
                ptr_q <= (grant_idx == CHW'(NCH-1)) ? '0 : grant_idx + 1'b1;
            if (is_data[grant_idx]) begin
                lock_q    <= 1'b1;
                lock_ch_q <= grant_idx;
            end else if (is_end[grant_idx]) begin
                lock_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/spk_in_mc.sv
// Multi-channel spike input: per-channel FIFOs, round-robin dispatch to axon/config,
// illegal-type dropping and sticky per-channel overflow flags.
module spk_in_mc
    import spk_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int B           = 4,
    parameter int FW          = 59,
    parameter int FTW         = 3,
    parameter int SW          = 24,
    parameter int CFG_CREDITS = 2,
    parameter int DCW         = 16,
    parameter int CHW         = (NCH > 1) ? spk_clog2(NCH) : 1
) (
    input  logic              clk_spk_in,
    input  logic              rst_n,
    input  logic [NCH*FW-1:0] flit_in,
    input  logic [NCH-1:0]    flit_in_wr,
    output logic [NCH-1:0]    credit_out,
    input  logic              config_spk_in_credit,
    output logic              spk_in_config_we,
    output logic [FW-1:0]     spk_in_config_wdata,
    output logic [CHW-1:0]    spk_in_config_src,
    input  logic              axon_busy,
    output logic              spk_in_axon_vld,
    output logic [SW-1:0]     spk_in_axon_data,
    output logic [FTW-1:0]    spk_in_axon_type,
    output logic [CHW-1:0]    spk_in_axon_src,
    output logic [DCW-1:0]    drop_cnt,
    output logic [NCH-1:0]    fifo_overflow
);
    localparam int CCW = spk_clog2(CFG_CREDITS + 1);

    logic [FW-1:0]  heads [NCH];
    logic [NCH-1:0] req, is_data_v, is_end_v, pop;
    logic           grant_vld;
    logic [CHW-1:0] grant_idx;
    logic [FW-1:0]  g_flit;
    logic [FTW-1:0] g_type;
    logic           g_axon, g_cfg, g_drop;
    logic [CCW-1:0] cred_q, cred_d;

    logic           axon_vld_q, cfg_we_q;
    logic [SW-1:0]  axon_data_q;
    logic [FTW-1:0] axon_type_q;
    logic [CHW-1:0] axon_src_q, cfg_src_q;
    logic [FW-1:0]  cfg_wdata_q;
    logic [DCW-1:0] drop_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic           empty, full, ovf_q;
        logic [FW-1:0]  head;
        logic [FTW-1:0] htype;

        data_fifo #(.DATA_WIDTH(FW), .ADDR_WIDTH(B)) u_fifo (
            .clk     (clk_spk_in),
            .rst_n   (rst_n),
            .wr_en   (flit_in_wr[gi]),
            .wr_data (flit_in[gi*FW +: FW]),
            .rd_en   (pop[gi]),
            .rd_data (head),
            .empty   (empty),
            .full    (full)
        );

        assign htype         = head[FW-1 -: FTW];
        assign heads[gi]     = head;
        assign is_data_v[gi] = (3'(htype) == DATA);
        assign is_end_v[gi]  = (3'(htype) == DATA_END);
        // Illegal heads are always eligible so they can be drained and counted.
        assign req[gi] = !empty && (is_axon(3'(htype)) ? !axon_busy :
                                    is_cfg(3'(htype))  ? (cred_q != '0) : 1'b1);

        always_ff @(posedge clk_spk_in or negedge rst_n) begin
            if (!rst_n)
                ovf_q <= 1'b0;
            else if (flit_in_wr[gi] && full && !pop[gi])
                ovf_q <= 1'b1;
        end
        assign fifo_overflow[gi] = ovf_q;
    end

    spk_in_rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
        .clk       (clk_spk_in),
        .rst_n     (rst_n),
        .req       (req),
        .is_data   (is_data_v),
        .is_end    (is_end_v),
        .grant_vld (grant_vld),
        .grant_oh  (pop),
        .grant_idx (grant_idx)
    );

    assign credit_out = pop;
    assign g_flit     = heads[grant_idx];
    assign g_type     = g_flit[FW-1 -: FTW];
    assign g_axon     = grant_vld && is_axon(3'(g_type));
    assign g_cfg      = grant_vld && is_cfg(3'(g_type));
    assign g_drop     = grant_vld && !is_axon(3'(g_type)) && !is_cfg(3'(g_type));

    always_comb begin
        cred_d = cred_q;
        if (g_cfg && !config_spk_in_credit)
            cred_d = cred_q - 1'b1;
        else if (!g_cfg && config_spk_in_credit && cred_q != CCW'(CFG_CREDITS))
            cred_d = cred_q + 1'b1;
    end

    always_ff @(posedge clk_spk_in or negedge rst_n) begin
        if (!rst_n) begin
            axon_vld_q  <= 1'b0;
            axon_data_q <= '0;
            axon_type_q <= '0;
            axon_src_q  <= '0;
            cfg_we_q    <= 1'b0;
            cfg_wdata_q <= '0;
            cfg_src_q   <= '0;
            drop_q      <= '0;
            cred_q      <= CCW'(CFG_CREDITS);
        end else begin
            axon_vld_q <= g_axon;
            cfg_we_q   <= g_cfg;
            cred_q     <= cred_d;
            if (g_axon) begin
                axon_data_q <= g_flit[SW-1:0];
                axon_type_q <= g_type;
                axon_src_q  <= grant_idx;
            end
            if (g_cfg) begin
                cfg_wdata_q <= g_flit;
                cfg_src_q   <= grant_idx;
            end
            if (g_drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign spk_in_axon_vld     = axon_vld_q;
    assign spk_in_axon_data    = axon_data_q;
    assign spk_in_axon_type    = axon_type_q;
    assign spk_in_axon_src     = axon_src_q;
    assign spk_in_config_we    = cfg_we_q;
    assign spk_in_config_wdata = cfg_wdata_q;
    assign spk_in_config_src   = cfg_src_q;
    assign drop_cnt            = drop_q;
endmodule

// File: tb/tb_spk_in_mc.sv
// Bench for spk_in_mc: directed scenarios plus random traffic against a queue-level model.
module tb_spk_in_mc;
    localparam int NCH = 4, B = 4, FW = 59, FTW = 3, SW = 24, CFG = 2, DCW = 16, CHW = 2;
    localparam int DEPTH = 1 << B;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH*FW-1:0] flit_in = '0;
    logic [NCH-1:0]    flit_in_wr = '0;
    logic [NCH-1:0]    credit_out;
    logic              config_spk_in_credit = 1'b0;
    logic              spk_in_config_we;
    logic [FW-1:0]     spk_in_config_wdata;
    logic [CHW-1:0]    spk_in_config_src;
    logic              axon_busy = 1'b0;
    logic              spk_in_axon_vld;
    logic [SW-1:0]     spk_in_axon_data;
    logic [FTW-1:0]    spk_in_axon_type;
    logic [CHW-1:0]    spk_in_axon_src;
    logic [DCW-1:0]    drop_cnt;
    logic [NCH-1:0]    fifo_overflow;

    spk_in_mc dut (
        .clk_spk_in           (clk),
        .rst_n                (rst_n),
        .flit_in              (flit_in),
        .flit_in_wr           (flit_in_wr),
        .credit_out           (credit_out),
        .config_spk_in_credit (config_spk_in_credit),
        .spk_in_config_we     (spk_in_config_we),
        .spk_in_config_wdata  (spk_in_config_wdata),
        .spk_in_config_src    (spk_in_config_src),
        .axon_busy            (axon_busy),
        .spk_in_axon_vld      (spk_in_axon_vld),
        .spk_in_axon_data     (spk_in_axon_data),
        .spk_in_axon_type     (spk_in_axon_type),
        .spk_in_axon_src      (spk_in_axon_src),
        .drop_cnt             (drop_cnt),
        .fifo_overflow        (fifo_overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: per-channel circular queues and scalar arbitration state.
    logic [FW-1:0]  m_mem [NCH][DEPTH];
    int             m_hd [NCH];
    int             m_cnt [NCH];
    int             m_ptr, m_lch, m_cred, m_drop;
    bit             m_lock;
    logic [NCH-1:0] m_ovf;
    logic           e_vld, e_we;
    logic [SW-1:0]  e_adata;
    logic [FTW-1:0] e_atype;
    logic [CHW-1:0] e_asrc, e_csrc;
    logic [FW-1:0]  e_wdata;

    // Observation log of DUT output events, read by the directed scenarios.
    int n_vld = 0, n_we = 0;
    int n_cred [NCH] = '{default: 0};
    int obs_src [$];
    int obs_data [$];
    int obs_type [$];

    always @(negedge clk) begin
        int g, c, t;
        logic [FW-1:0]  f;
        logic [NCH-1:0] exp_credit;
        bit cfg_g;
        exp_credit = '0;
        g = -1;
        cfg_g = 0;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_hd[i] = 0;
                m_cnt[i] = 0;
            end
            m_ovf = '0; m_ptr = 0; m_lock = 0; m_lch = 0; m_cred = CFG; m_drop = 0;
            e_vld = 0; e_we = 0; e_adata = '0; e_atype = '0; e_asrc = '0;
            e_csrc = '0; e_wdata = '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (g < 0 && (!m_lock || c == m_lch) && m_cnt[c] > 0) begin
                    t = int'(m_mem[c][m_hd[c]][FW-1 -: FTW]);
                    if ((t <= 2 && !axon_busy) || (t >= 6 && m_cred > 0) || (t >= 3 && t <= 5))
                        g = c;
                end
            end
            if (g >= 0) exp_credit[g] = 1'b1;
        end

        chk("credit_out", credit_out, exp_credit);
        chk("axon_vld", spk_in_axon_vld, e_vld);
        chk("axon_data", spk_in_axon_data, e_adata);
        chk("axon_type", spk_in_axon_type, e_atype);
        chk("axon_src", spk_in_axon_src, e_asrc);
        chk("config_we", spk_in_config_we, e_we);
        chk("config_wdata", spk_in_config_wdata, e_wdata);
        chk("config_src", spk_in_config_src, e_csrc);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("fifo_overflow", fifo_overflow, m_ovf);

        if (spk_in_axon_vld) begin
            n_vld++;
            obs_src.push_back(int'(spk_in_axon_src));
            obs_data.push_back(int'(spk_in_axon_data));
            obs_type.push_back(int'(spk_in_axon_type));
        end
        if (spk_in_config_we) n_we++;
        for (int i = 0; i < NCH; i++) n_cred[i] += int'(credit_out[i]);

        if (rst_n) begin
            e_vld = 0;
            e_we = 0;
            if (g >= 0) begin
                f = m_mem[g][m_hd[g]];
                m_hd[g] = (m_hd[g] + 1) % DEPTH;
                m_cnt[g]--;
                t = int'(f[FW-1 -: FTW]);
                if (t <= 2) begin
                    e_vld = 1; e_adata = f[SW-1:0]; e_atype = FTW'(t); e_asrc = CHW'(g);
                end else if (t >= 6) begin
                    e_we = 1; e_wdata = f; e_csrc = CHW'(g); cfg_g = 1;
                end else if (m_drop < (1 << DCW) - 1) begin
                    m_drop++;
                end
                if (!m_lock) m_ptr = (g + 1) % NCH;
                if (t == 1) begin
                    m_lock = 1; m_lch = g;
                end else if (t == 2) begin
                    m_lock = 0;
                end
            end
            if (cfg_g && !config_spk_in_credit) m_cred--;
            else if (!cfg_g && config_spk_in_credit && m_cred < CFG) m_cred++;
            for (int i = 0; i < NCH; i++) begin
                if (flit_in_wr[i]) begin
                    if (m_cnt[i] < DEPTH) begin
                        m_mem[i][(m_hd[i] + m_cnt[i]) % DEPTH] = flit_in[i*FW +: FW];
                        m_cnt[i]++;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [FW-1:0] mk(input int t, input int p);
        logic [FW-1:0] f;
        f = {$urandom, $urandom};
        f[FW-1 -: FTW] = FTW'(t);
        f[SW-1:0] = SW'(p);
        return f;
    endfunction

    task automatic put(input int ch, input logic [FW-1:0] f);
        flit_in_wr[ch] = 1'b1;
        flit_in[ch*FW +: FW] = f;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            flit_in_wr = '0;
            config_spk_in_credit = 1'b0;
        end
    endtask

    initial begin
        int s0, v0, w0, c0, p1, n1, last1;
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Simultaneous SPIKEs on all channels drain in channel order.
        s0 = obs_src.size();
        for (int i = 0; i < NCH; i++) put(i, mk(0, i));
        tick(8);
        chk("t1_count", obs_src.size() - s0, 4);
        if (obs_src.size() - s0 >= 4)
            for (int k = 0; k < 4; k++) begin
                chk("t1_src", obs_src[s0+k], k);
                chk("t1_data", obs_data[s0+k], k);
            end

        // A DATA packet on ch1 is delivered contiguously while ch0 streams.
        s0 = obs_src.size();
        for (int k = 0; k < 8; k++) begin
            put(0, mk(0, 100 + k));
            if (k < 2) put(1, mk(1, 200 + k));
            if (k == 2) put(1, mk(2, 202));
            tick(1);
        end
        tick(10);
        p1 = -1; n1 = 0; last1 = -1;
        for (int k = s0; k < obs_src.size(); k++)
            if (obs_src[k] == 1) begin
                if (p1 < 0) p1 = k;
                last1 = k;
                n1++;
            end
        chk("t2_ch1_count", n1, 3);
        chk("t2_ch1_span", last1 - p1, 2);
        chk("t2_total", obs_src.size() - s0, 11);

        // Config window of two credits holds the third WRITE until a credit returns.
        w0 = n_we;
        for (int k = 0; k < 3; k++) begin
            put(2, mk(6, 300 + k));
            tick(1);
        end
        tick(5);
        chk("t3_we_before_credit", n_we - w0, 2);
        config_spk_in_credit = 1'b1;
        tick(4);
        chk("t3_we_after_credit", n_we - w0, 3);
        config_spk_in_credit = 1'b1;
        tick(1);
        config_spk_in_credit = 1'b1;
        tick(1);

        // Illegal type is dropped with a credit, then traffic continues.
        c0 = n_cred[3]; v0 = n_vld;
        put(3, mk(4, 400));
        tick(4);
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_credit", n_cred[3] - c0, 1);
        chk("t4_no_vld", n_vld - v0, 0);
        put(3, mk(0, 401));
        tick(4);
        chk("t4_spike_after", n_vld - v0, 1);

        // Overflow of ch0 while the axon is busy.
        axon_busy = 1'b1;
        c0 = n_cred[0]; v0 = n_vld;
        for (int k = 0; k < 17; k++) begin
            put(0, mk(0, 500 + k));
            tick(1);
        end
        tick(2);
        chk("t5_overflow", fifo_overflow[0], 1'b1);
        axon_busy = 1'b0;
        tick(20);
        chk("t5_credits", n_cred[0] - c0, 16);
        chk("t5_vld", n_vld - v0, 16);

        // Reset while locked and partially full, then a fresh SPIKE on ch3.
        put(1, mk(1, 600));
        tick(3);
        axon_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            put(0, mk(0, 610 + k));
            put(1, mk(0, 620 + k));
            tick(1);
        end
        rst_n = 1'b0;
        axon_busy = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        v0 = n_vld; s0 = obs_src.size();
        put(3, mk(0, 777));
        tick(5);
        chk("t6_vld", n_vld - v0, 1);
        if (obs_src.size() > s0) chk("t6_src", obs_src[s0], 3);

        // Random traffic with busy and credit returns.
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(2) == 0) put(i, mk($urandom_range(7), $urandom));
            axon_busy = ($urandom_range(3) == 0);
            config_spk_in_credit = ($urandom_range(3) == 0);
            tick(1);
        end
        axon_busy = 1'b0;
        for (int k = 0; k < 80; k++) begin
            config_spk_in_credit = 1'b1;
            if (k % 10 == 0) begin
                for (int i = 0; i < NCH; i++) put(i, mk(2, k));
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
